// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences CPU loads and stores onto a single-port,
// doubleword-wide synchronous data memory. Loads are extracted and extended
// from the captured doubleword. Sub-doubleword stores are done as
// read-modify-write. Illegal requests are answered with an error response
// and never touch memory.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] Address,
    input  logic [63:0] Write_data,
    output logic        resp_valid,
    output logic [63:0] ReadData,
    output logic        access_err,
    output logic [9:0]  mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_is_load;
    logic [2:0]  r_funct3;
    logic [12:0] r_addr;
    logic        r_err;
    logic [63:0] r_rdata;
    logic [63:0] r_wdata;    // store data, later the merged RMW doubleword

    logic        w_accept;
    logic        w_err;
    logic        w_misalign;

    // Byte lanes touched by an access of 2^sz bytes at byte offset off.
    function automatic logic [7:0] f_byte_en(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] be;
        case (sz)
            2'b00:   be = 8'h01;
            2'b01:   be = 8'h03;
            2'b10:   be = 8'h0F;
            default: be = 8'hFF;
        endcase
        return be << off;
    endfunction

    // Shift the addressed bytes down, truncate to the access size, then extend.
    function automatic logic [63:0] f_extract(input logic [63:0] word, input logic [2:0] off,
                                              input logic [2:0] f3);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   res = f3[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'b01:   res = f3[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'b10:   res = f3[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Replace the addressed byte lanes of word with the low bytes of data.
    function automatic logic [63:0] f_merge(input logic [63:0] word, input logic [63:0] data,
                                            input logic [2:0] off, input logic [1:0] sz);
        logic [7:0]  be;
        logic [63:0] sh_data;
        logic [63:0] mask;
        be      = f_byte_en(sz, off);
        sh_data = data << {off, 3'b000};
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return (word & ~mask) | (sh_data & mask);
    endfunction

    assign w_accept = req_valid && (r_state == IDLE);

    // Classify the presented request as legal or erroneous.
    always_comb begin
        w_misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   w_misalign = Address[0];
            2'b10:   w_misalign = |Address[1:0];
            2'b11:   w_misalign = |Address[2:0];
            default: w_misalign = 1'b0;
        endcase
        w_err = (MemRead == MemWrite)
              | (MemRead && (funct3 == 3'b111))
              | (MemWrite && funct3[2])
              | (|Address[63:13])
              | w_misalign;
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and memory/handshake strobes decoded from the current state.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_err)                   w_next = RESP;
                    else if (MemRead)            w_next = RD;
                    else if (funct3[1:0] == 2'b11) w_next = WR;
                    else                         w_next = RD;
                end
            end
            RD: begin
                mem_read = 1'b1;
                w_next   = CAP;
            end
            CAP: begin
                w_next = r_is_load ? RESP : WR;
            end
            WR: begin
                mem_write = 1'b1;
                w_next    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign access_err = resp_valid && r_err;
    assign mem_addr   = r_addr[12:3];
    assign mem_wdata  = r_wdata;
    assign ReadData   = r_rdata;

    // Request latch, load result capture and store-word assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= 13'd0;
            r_err     <= 1'b0;
            r_rdata   <= 64'd0;
            r_wdata   <= 64'd0;
        end else begin
            if (w_accept) begin
                r_is_load <= MemRead;
                r_funct3  <= funct3;
                r_addr    <= Address[12:0];
                r_err     <= w_err;
                if (MemWrite) begin
                    r_wdata <= Write_data;
                end
            end
            if (r_state == CAP) begin
                if (r_is_load) begin
                    r_rdata <= f_extract(mem_rdata, r_addr[2:0], r_funct3);
                end else begin
                    r_wdata <= f_merge(mem_rdata, r_wdata, r_addr[2:0], r_funct3[1:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases followed by random accesses,
// checked against a byte-addressed reference memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [63:0] Address;
    logic [63:0] Write_data;
    logic        resp_valid;
    logic [63:0] ReadData;
    logic        access_err;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_rdata;

    logic [63:0] mem [0:1023];
    logic        init_go = 1'b0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  ref_mem [0:8191];
    logic [63:0] exp_rdata;

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .Address    (Address),
        .Write_data (Write_data),
        .resp_valid (resp_valid),
        .ReadData   (ReadData),
        .access_err (access_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int i);
        if (i == 2) return 64'h8877665544332211;
        return {32'(i) * 32'h9E3779B9 ^ 32'h5A5A1234, 32'(i) * 32'h85EBCA6B + 32'h0F0F77AA};
    endfunction

    // Synchronous data memory with one-cycle read latency and strobe counters.
    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_read) begin
                mem_rdata <= mem[mem_addr];
                rd_pulses <= rd_pulses + 1;
            end
            if (mem_write) begin
                mem[mem_addr] <= mem_wdata;
                wr_pulses     <= wr_pulses + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input int idx);
        logic [63:0] w;
        w = 64'd0;
        for (int k = 0; k < 8; k++) w |= 64'(ref_mem[idx*8 + k]) << (8*k);
        return w;
    endfunction

    // One complete request: model prediction, drive, wait for the response, compare.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wdata);
        int          size, lat, exp_r, exp_w, r0, w0, cyc, ai;
        logic        err, got;
        logic [63:0] val, exp_wd;
        size   = 1 << f3[1:0];
        err    = (rd == wr) || (rd && f3 == 3'b111) || (wr && f3[2]) ||
                 (addr >= 64'd8192) || ((addr % 64'(size)) != 64'd0);
        ai     = int'(addr[12:0]);
        exp_wd = 64'd0;
        if (err) begin
            lat = 1; exp_r = 0; exp_w = 0;
        end else if (rd) begin
            lat = 3; exp_r = 1; exp_w = 0;
            val = 64'd0;
            for (int k = 0; k < size; k++) val |= 64'(ref_mem[ai + k]) << (8*k);
            if (!f3[2] && size < 8 && val[8*size-1]) val |= ~64'd0 << (8*size);
            exp_rdata = val;
        end else begin
            lat   = (size < 8) ? 4 : 2;
            exp_r = (size < 8) ? 1 : 0;
            exp_w = 1;
            for (int k = 0; k < size; k++) ref_mem[ai + k] = wdata[8*k +: 8];
            exp_wd = ref_word(ai / 8);
        end

        @(negedge clk);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        r0         = rd_pulses;
        w0         = wr_pulses;
        req_valid  = 1'b1;
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        Address    = addr;
        Write_data = wdata;
        @(posedge clk);
        #1;
        // Keep req_valid high with junk inputs: the busy unit must ignore them.
        MemRead    = 1'($urandom);
        MemWrite   = 1'($urandom);
        funct3     = 3'($urandom);
        Address    = {$urandom, $urandom};
        Write_data = {$urandom, $urandom};

        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            check("strobe_exclusive", {63'd0, mem_read && mem_write}, 64'd0);
            if (mem_read || mem_write) check("mem_addr", {54'd0, mem_addr}, {54'd0, addr[12:3]});
            if (mem_write) check("mem_wdata", mem_wdata, exp_wd);
            if (resp_valid) got = 1'b1;
            else check("err_without_resp", {63'd0, access_err}, 64'd0);
        end
        req_valid = 1'b0;
        check("resp_seen", {63'd0, got}, 64'd1);
        check("latency", 64'(cyc), 64'(lat));
        check("access_err", {63'd0, access_err}, {63'd0, err});
        check("ReadData", ReadData, exp_rdata);
        check("read_pulses", 64'(rd_pulses - r0), 64'(exp_r));
        check("write_pulses", 64'(wr_pulses - w0), 64'(exp_w));
    endtask

    initial begin
        logic        rd, wr, seen;
        logic [2:0]  f3;
        logic [63:0] addr;
        int          kind, size, w0;

        rst_n      = 1'b1;
        req_valid  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        funct3     = 3'd0;
        Address    = 64'd0;
        Write_data = 64'd0;
        exp_rdata  = 64'd0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_access_err", {63'd0, access_err}, 64'd0);
        check("rst_ReadData", ReadData, 64'd0);
        check("rst_mem_read", {63'd0, mem_read}, 64'd0);
        check("rst_mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_mem_addr", {54'd0, mem_addr}, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);

        init_go = 1'b1;
        @(posedge clk);
        #1 init_go = 1'b0;
        for (int i = 0; i < 1024; i++)
            for (int k = 0; k < 8; k++) ref_mem[i*8 + k] = init_word(i) >> (8*k);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed loads from the known doubleword at index 2.
        do_access(1, 0, 3'b000, 64'h17, 64'd0);
        check("lb_0x17_value", ReadData, 64'hFFFFFFFFFFFFFF88);
        do_access(1, 0, 3'b101, 64'h12, 64'd0);
        check("lhu_0x12_value", ReadData, 64'h0000000000004433);
        do_access(1, 0, 3'b010, 64'h14, 64'd0);
        check("lw_0x14_value", ReadData, 64'hFFFFFFFF88776655);

        // Halfword RMW store, then back-to-back reload of the same doubleword.
        do_access(0, 1, 3'b001, 64'h14, 64'h000000000000ABCD);
        check("sh_mem_word", mem[2], 64'h8877ABCD44332211);
        check("sh_keeps_ReadData", ReadData, 64'hFFFFFFFF88776655);
        do_access(1, 0, 3'b011, 64'h10, 64'd0);
        check("ld_after_sh", ReadData, 64'h8877ABCD44332211);

        // Full doubleword store and the error cases.
        do_access(0, 1, 3'b011, 64'h08, 64'h0123456789ABCDEF);
        check("sd_mem_word", mem[1], 64'h0123456789ABCDEF);
        do_access(1, 0, 3'b010, 64'h06, 64'd0);
        do_access(1, 1, 3'b011, 64'h10, 64'd0);
        do_access(0, 0, 3'b011, 64'h10, 64'd0);
        do_access(1, 0, 3'b111, 64'h10, 64'd0);
        do_access(0, 1, 3'b100, 64'h10, 64'd5);
        do_access(1, 0, 3'b011, 64'h2000, 64'd0);
        do_access(1, 0, 3'b001, 64'h11, 64'd0);

        // Reset asserted during the WR cycle of a byte store.
        @(negedge clk);
        req_valid  = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b1;
        funct3     = 3'b000;
        Address    = 64'h10;
        Write_data = 64'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (mem_write) seen = 1'b1;
        end
        check("sb_reached_wr", {63'd0, seen}, 64'd1);
        w0    = wr_pulses;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_write", {63'd0, mem_write}, 64'd0);
        check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        check("midrst_ReadData", ReadData, 64'd0);
        exp_rdata = 64'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_no_resp", {63'd0, resp_valid}, 64'd0);
        end
        check("midrst_no_write", 64'(wr_pulses - w0), 64'd0);
        do_access(1, 0, 3'b011, 64'h10, 64'd0);
        check("ld_after_abandon", ReadData, 64'h8877ABCD44332211);

        // Random accesses confined to a few doublewords so stores and loads collide.
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 99);
            rd   = (kind < 45);
            wr   = !rd;
            if (kind >= 95) begin
                rd = 1'($urandom);
                wr = rd;
            end
            if (rd) f3 = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 19) == 0) f3 = 3'($urandom_range(4, 7));
            else f3 = 3'($urandom_range(0, 3));
            size = 1 << f3[1:0];
            addr = 64'($urandom_range(0, 7) * 8);
            if ($urandom_range(0, 9) == 0) addr += 64'($urandom_range(0, 7));
            else addr += 64'(($urandom_range(0, 7) / size) * size);
            if ($urandom_range(0, 29) == 0) addr |= 64'd1 << $urandom_range(13, 63);
            do_access(rd, wr, f3, addr, {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
